// File: rtl/allocator_separable_rr_hold_if.sv
// Allocator request/grant bundle.
//   requests    [i][j] requestor i wants resource j
//   release_req [i]    requestor i frees its held resource. The name is not
//                      "release" because that word is a reserved keyword.
//   grants      [i][j] resource j granted to requestor i (registered)
//   res_busy    [j]    resource j is held by a lock
// The master modport is the requestor side and the slave modport is the allocator.
interface allocator_separable_rr_hold_if #(
  parameter int NUM_REQS = 4,
  parameter int NUM_RESS = 4
);
  logic [NUM_REQS-1:0][NUM_RESS-1:0] requests;
  logic [NUM_REQS-1:0]               release_req;
  logic [NUM_REQS-1:0][NUM_RESS-1:0] grants;
  logic [NUM_RESS-1:0]               res_busy;

  modport master (output requests, output release_req, input grants, input res_busy);
  modport slave  (input requests, input release_req, output grants, output res_busy);
endinterface

// File: rtl/allocator_separable_rr_hold.sv
// Separable round-robin allocator. It uses two arbiter stages: input-first or
// output-first. Pointers follow the iSLIP rule and grants are registered. An
// optional packet-level hold locks a granted pair until it is released.
//   clk    clock
//   reset  synchronous, active-low reset
//   bus    allocator_separable_rr_hold_if.slave (requests/release_req in, grants/res_busy out)
module allocator_separable_rr_hold #(
  parameter int NUM_REQS     = 4,
  parameter int NUM_RESS     = 4,
  parameter int OUTPUT_FIRST = 0,
  parameter int HOLD_EN      = 0
) (
  input  logic clk,
  input  logic reset,
  allocator_separable_rr_hold_if.slave bus
);
  localparam int RQW  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int RSW  = (NUM_RESS > 1) ? $clog2(NUM_RESS) : 1;
  localparam bit HOLD = (HOLD_EN != 0);

  logic [NUM_REQS-1:0][NUM_RESS-1:0] grants_reg, grants_next;
  logic [NUM_RESS-1:0]               lock_valid_reg, lock_valid_next;
  logic [NUM_RESS-1:0][RQW-1:0]      lock_owner_reg, lock_owner_next;
  logic [NUM_REQS-1:0][RSW-1:0]      in_ptr_reg, in_ptr_next;   // per requestor, over resources
  logic [NUM_RESS-1:0][RQW-1:0]      out_ptr_reg, out_ptr_next; // per resource, over requestors

  logic [NUM_RESS-1:0]               keep_lock;
  logic [NUM_REQS-1:0][NUM_RESS-1:0] held, elig, new_grant;
  logic [NUM_RESS-1:0][NUM_REQS-1:0] elig_t;
  logic [NUM_REQS-1:0]               holds_lock;

  // Round-robin pick over resources, starting at ptr and wrapping.
  function automatic logic [NUM_RESS-1:0] rr_res(input logic [NUM_RESS-1:0] req,
                                                 input logic [RSW-1:0] ptr);
    logic [NUM_RESS-1:0] gnt;
    logic found;
    int idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_RESS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_RESS) idx = idx - NUM_RESS;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  // Round-robin pick over requestors, starting at ptr and wrapping.
  function automatic logic [NUM_REQS-1:0] rr_req(input logic [NUM_REQS-1:0] req,
                                                 input logic [RQW-1:0] ptr);
    logic [NUM_REQS-1:0] gnt;
    logic found;
    int idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  genvar gi, gj;

  // A lock survives this cycle only while its owner keeps requesting the
  // resource and does not release it. A dropped lock frees the resource for
  // this cycle's arbitration.
  for (gj = 0; gj < NUM_RESS; gj++) begin : g_keep
    assign keep_lock[gj] = HOLD && lock_valid_reg[gj]
                           && bus.requests[lock_owner_reg[gj]][gj]
                           && !bus.release_req[lock_owner_reg[gj]];
  end

  for (gi = 0; gi < NUM_REQS; gi++) begin : g_row
    for (gj = 0; gj < NUM_RESS; gj++) begin : g_col
      assign held[gi][gj]   = keep_lock[gj] && (lock_owner_reg[gj] == RQW'(gi));
      assign elig[gi][gj]   = bus.requests[gi][gj] && !keep_lock[gj] && !holds_lock[gi];
      assign elig_t[gj][gi] = elig[gi][gj];
    end
    assign holds_lock[gi] = |held[gi];
  end

  if (OUTPUT_FIRST != 0) begin : g_of
    logic [NUM_RESS-1:0][NUM_REQS-1:0] offer_t;
    logic [NUM_REQS-1:0][NUM_RESS-1:0] offer;
    for (gj = 0; gj < NUM_RESS; gj++) begin : g_s1
      assign offer_t[gj] = rr_req(elig_t[gj], out_ptr_reg[gj]);
    end
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_s2
      for (gj = 0; gj < NUM_RESS; gj++) begin : g_tr
        assign offer[gi][gj] = offer_t[gj][gi];
      end
      assign new_grant[gi] = rr_res(offer[gi], in_ptr_reg[gi]);
    end
  end else begin : g_if
    logic [NUM_REQS-1:0][NUM_RESS-1:0] bid;
    logic [NUM_RESS-1:0][NUM_REQS-1:0] bid_t, win_t;
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_s1
      assign bid[gi] = rr_res(elig[gi], in_ptr_reg[gi]);
      for (gj = 0; gj < NUM_RESS; gj++) begin : g_tr
        assign bid_t[gj][gi]     = bid[gi][gj];
        assign new_grant[gi][gj] = win_t[gj][gi];
      end
    end
    for (gj = 0; gj < NUM_RESS; gj++) begin : g_s2
      assign win_t[gj] = rr_req(bid_t[gj], out_ptr_reg[gj]);
    end
  end

  // Only fresh grants move the pointers and create locks. Held re-grants
  // leave both stages untouched.
  always_comb begin
    grants_next     = new_grant | held;
    in_ptr_next     = in_ptr_reg;
    out_ptr_next    = out_ptr_reg;
    lock_valid_next = keep_lock;
    lock_owner_next = lock_owner_reg;
    for (int i = 0; i < NUM_REQS; i++) begin
      for (int j = 0; j < NUM_RESS; j++) begin
        if (new_grant[i][j]) begin
          in_ptr_next[i]  = RSW'((j + 1) % NUM_RESS);
          out_ptr_next[j] = RQW'((i + 1) % NUM_REQS);
          if (HOLD) begin
            lock_valid_next[j] = 1'b1;
            lock_owner_next[j] = RQW'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grants_reg     <= '0;
      lock_valid_reg <= '0;
      lock_owner_reg <= '0;
      in_ptr_reg     <= '0;
      out_ptr_reg    <= '0;
    end else begin
      grants_reg     <= grants_next;
      lock_valid_reg <= lock_valid_next;
      lock_owner_reg <= lock_owner_next;
      in_ptr_reg     <= in_ptr_next;
      out_ptr_reg    <= out_ptr_next;
    end
  end

  assign bus.grants   = grants_reg;
  assign bus.res_busy = lock_valid_reg;
endmodule
